// File: rtl/sample_iter4.sv
// sample_iter4: walks a triangle's bounding box on the MSAA subsample grid, four adjacent samples per cycle.
// Optional: define SAMPLE_ITER_SNAP_EN to round the box lower-left corner down onto the subsample grid.
module sample_iter4 #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                   validTri_R13H,
  input  logic [3:0]                             subSample_RnnnnU,
  output logic                                   halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic [1:0][3:0][SIGFIG-1:0]            sample_R14S,
  output logic [3:0]                             validSamp_R14H
);

  localparam int W = SIGFIG + 1;
  typedef logic signed [W-1:0] wide_t;
  typedef enum logic {ST_WAIT, ST_TEST} state_t;

  function automatic wide_t ext(input logic [SIGFIG-1:0] v);
    return wide_t'({v[SIGFIG-1], v});
  endfunction

  state_t            state, state_next;
  logic [SIGFIG-1:0] cur_x, cur_y, ll_x, ur_x, ur_y;

  wide_t             step, nx, ny, grp_x, grp_ur;
  logic [SIGFIG-1:0] ll_in_x, ll_in_y, grp_y;
  wide_t             lane_x [4];
  logic [3:0]        lane_valid;
  logic              nx_ok, ny_ok, is_last, xfer, degen_in, load_new, advance;
`ifdef SAMPLE_ITER_SNAP_EN
  logic [SIGFIG-1:0] snap_mask;
`endif

  always_comb begin
    case (subSample_RnnnnU)
      4'b0100: step = wide_t'(1 << (RADIX - 1));
      4'b0010: step = wide_t'(1 << (RADIX - 2));
      4'b0001: step = wide_t'(1 << (RADIX - 3));
      default: step = wide_t'(1 << RADIX);
    endcase
  end

  always_comb begin
    ll_in_x = box_R13S[0][0];
    ll_in_y = box_R13S[0][1];
`ifdef SAMPLE_ITER_SNAP_EN
    // Clearing the low bits rounds toward minus infinity, also for negative corners.
    snap_mask = step[SIGFIG-1:0] - 1'b1;
    ll_in_x   = box_R13S[0][0] & ~snap_mask;
    ll_in_y   = box_R13S[0][1] & ~snap_mask;
`endif
  end

  // Handshake: a box transfers on a rising edge where validTri_R13H=1 and halt_RnnnnL=1.
  // halt_RnnnnL is high when idle or while the final group of the current box is on the outputs,
  // so the next box can follow the final group without a bubble; upstream holds its data otherwise.
  always_comb begin
    nx          = ext(cur_x) + (step <<< 2);
    ny          = ext(cur_y) + step;
    nx_ok       = nx <= ext(ur_x);
    ny_ok       = ny <= ext(ur_y);
    is_last     = (state == ST_TEST) && !nx_ok && !ny_ok;
    halt_RnnnnL = (state == ST_WAIT) || is_last;
    xfer        = validTri_R13H && halt_RnnnnL;
    degen_in    = (ext(box_R13S[1][0]) < ext(box_R13S[0][0])) ||
                  (ext(box_R13S[1][1]) < ext(box_R13S[0][1]));
    load_new    = xfer && !degen_in;
    advance     = (state == ST_TEST) && !is_last;
    state_next  = (load_new || advance) ? ST_TEST : ST_WAIT;

    // Position of the group that goes on the outputs after this edge.
    grp_x  = load_new ? ext(ll_in_x) : (nx_ok ? nx : ext(ll_x));
    grp_y  = load_new ? ll_in_y : (nx_ok ? cur_y : ny[SIGFIG-1:0]);
    grp_ur = load_new ? ext(box_R13S[1][0]) : ext(ur_x);

    lane_x[0] = grp_x;
    for (int i = 1; i < 4; i++) lane_x[i] = lane_x[i-1] + step;
    for (int i = 0; i < 4; i++) lane_valid[i] = lane_x[i] <= grp_ur;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_WAIT;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_x          <= '0;
      cur_y          <= '0;
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
    end else begin
      if (load_new) begin
        tri_R14S   <= tri_R13S;
        color_R14U <= color_R13U;
        ll_x       <= ll_in_x;
        ur_x       <= box_R13S[1][0];
        ur_y       <= box_R13S[1][1];
      end
      if (load_new || advance) begin
        cur_x <= grp_x[SIGFIG-1:0];
        cur_y <= grp_y;
        for (int i = 0; i < 4; i++) begin
          sample_R14S[0][i] <= lane_x[i][SIGFIG-1:0];
          sample_R14S[1][i] <= grp_y;
        end
        validSamp_R14H <= lane_valid;
      end else begin
        // Idle: lanes go invalid while sample/tri/color keep their last values.
        validSamp_R14H <= '0;
      end
    end
  end

  // The subsample rate select must always be exactly one-hot.
  a_subsample_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot(subSample_RnnnnU));

endmodule

// File: tb/tb_sample_iter4.sv
// tb_sample_iter4: randomized and directed bench for sample_iter4 against a box-walking reference model.
// Build with SAMPLE_ITER_SNAP_EN defined to check the lower-left snapping variant.
module tb_sample_iter4;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int W      = 1 + 4 + 8 * SIGFIG;

  logic                                   clk = 1'b0;
  logic                                   rst;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                   validTri_R13H;
  logic [3:0]                             subSample_RnnnnU;
  logic                                   halt_RnnnnL;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic [1:0][3:0][SIGFIG-1:0]            sample_R14S;
  logic [3:0]                             validSamp_R14H;

  sample_iter4 #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
    .clk(clk), .rst(rst), .tri_R13S(tri_R13S), .color_R13U(color_R13U), .box_R13S(box_R13S),
    .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU), .halt_RnnnnL(halt_RnnnnL),
    .tri_R14S(tri_R14S), .color_R14U(color_R14U), .sample_R14S(sample_R14S),
    .validSamp_R14H(validSamp_R14H)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int step   = 1024;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_t[$];
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] last_tri;
  logic [COLORS-1:0][SIGFIG-1:0]          last_color;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every output group with valid lanes, tagged with halt and cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && validSamp_R14H !== 4'b0000) begin
      obs_q.push_back({halt_RnnnnL, validSamp_R14H, sample_R14S[0], sample_R14S[1]});
      obs_t.push_back(cycle);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] pack_word(input logic last, input logic [3:0] v,
                                             input int x, input int y, input int s);
    logic [3:0][SIGFIG-1:0] xs, ys;
    for (int i = 0; i < 4; i++) begin
      xs[i] = SIGFIG'(x + i * s);
      ys[i] = SIGFIG'(y);
    end
    return {last, v, xs, ys};
  endfunction

  task automatic model_box(input int llx, input int lly, input int urx, input int ury);
    logic [3:0] v;
    logic       last;
    if (urx < llx || ury < lly) return;
`ifdef SAMPLE_ITER_SNAP_EN
    llx = llx - (((llx % step) + step) % step);
    lly = lly - (((lly % step) + step) % step);
`endif
    for (int y = lly; y <= ury; y += step) begin
      for (int x = llx; x <= urx; x += 4 * step) begin
        for (int i = 0; i < 4; i++) v[i] = (x + i * step <= urx);
        last = (x + 4 * step > urx) && (y + step > ury);
        exp_q.push_back(pack_word(last, v, x, y, step));
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_msaa(input int k);
    subSample_RnnnnU = 4'b1000 >> k;
    step             = 1024 >> k;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
  endtask

  // Called on a falling edge; returns on the falling edge right after the transfer.
  task automatic drive_box(input int llx, input int lly, input int urx, input int ury);
    int n = 0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) tri_R13S[v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++) color_R13U[c] = SIGFIG'($urandom);
    box_R13S[0][0] = SIGFIG'(llx);
    box_R13S[0][1] = SIGFIG'(lly);
    box_R13S[1][0] = SIGFIG'(urx);
    box_R13S[1][1] = SIGFIG'(ury);
    validTri_R13H  = 1'b1;
    last_tri       = tri_R13S;
    last_color     = color_R13U;
    while (halt_RnnnnL !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL handshake_timeout: halt stayed %b for %0d cycles, required 1", halt_RnnnnL, n);
    end
    @(negedge clk);
    validTri_R13H = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((validSamp_R14H !== 4'b0000 || halt_RnnnnL !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL idle_timeout: valid=%b halt=%b after %0d cycles, required 0000/1", validSamp_R14H, halt_RnnnnL, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (halt_RnnnnL !== 1'b1) begin errors++; $display("FAIL reset_halt: got %b, required 1", halt_RnnnnL); end
    checks++;
    if (validSamp_R14H !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b, required 0000", validSamp_R14H); end
    checks++;
    if (sample_R14S !== '0) begin errors++; $display("FAIL reset_sample: got %h, required 0", sample_R14S); end
    checks++;
    if (tri_R14S !== '0 || color_R14U !== '0) begin errors++; $display("FAIL reset_tri_color: got %h/%h, required 0", tri_R14S, color_R14U); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (halt_RnnnnL !== 1'b1) begin errors++; $display("FAIL post_reset_halt: got %b, required 1", halt_RnnnnL); end
  endtask

  task automatic test_msaa1();
    set_msaa(0);
    clear_queues();
    drive_box(0, 0, 3072, 0);
    checks++;
    if (sample_R14S[0] !== {24'd3072, 24'd2048, 24'd1024, 24'd0}) begin
      errors++; $display("FAIL msaa1_x: got %h, required 0/1024/2048/3072", sample_R14S[0]);
    end
    checks++;
    if (sample_R14S[1] !== '0) begin errors++; $display("FAIL msaa1_y: got %h, required 0", sample_R14S[1]); end
    checks++;
    if (validSamp_R14H !== 4'b1111) begin errors++; $display("FAIL msaa1_valid: got %b, required 1111", validSamp_R14H); end
    checks++;
    if (halt_RnnnnL !== 1'b1) begin errors++; $display("FAIL msaa1_halt: got %b, required 1", halt_RnnnnL); end
    checks++;
    if (tri_R14S !== last_tri || color_R14U !== last_color) begin
      errors++; $display("FAIL msaa1_tri_color: got %h/%h, required %h/%h", tri_R14S, color_R14U, last_tri, last_color);
    end
    @(negedge clk);
    checks++;
    if (validSamp_R14H !== 4'b0000) begin errors++; $display("FAIL msaa1_after_valid: got %b, required 0000", validSamp_R14H); end
    checks++;
    if (sample_R14S[0] !== {24'd3072, 24'd2048, 24'd1024, 24'd0} || tri_R14S !== last_tri) begin
      errors++; $display("FAIL msaa1_hold: got %h, required held values", sample_R14S[0]);
    end
  endtask

  task automatic test_msaa4();
    set_msaa(1);
    clear_queues();
    exp_q.push_back(pack_word(1'b0, 4'b1111, 0, 0, 512));
    exp_q.push_back(pack_word(1'b0, 4'b0011, 2048, 0, 512));
    exp_q.push_back(pack_word(1'b0, 4'b1111, 0, 512, 512));
    exp_q.push_back(pack_word(1'b1, 4'b0011, 2048, 512, 512));
    drive_box(0, 0, 2560, 512);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL msaa4_count: got %0d groups, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL msaa4_group%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    set_msaa(1);
    clear_queues();
    model_box(0, 0, 1536, 512);
    model_box(-1024, -512, 1024, 0);
    drive_box(0, 0, 1536, 512);
    drive_box(-1024, -512, 1024, 0);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d groups, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_group%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
      checks++;
      if (obs_t[i] != obs_t[0] + i) begin errors++; $display("FAIL b2b_gap%0d: group at cycle %0d, required %0d", i, obs_t[i], obs_t[0] + i); end
    end
    checks++;
    if (tri_R14S !== last_tri) begin errors++; $display("FAIL b2b_tri: got %h, required %h", tri_R14S, last_tri); end
  endtask

  task automatic test_degenerate();
    int c;
    set_msaa(0);
    clear_queues();
    drive_box(2048, 0, 1024, 0);
    checks++;
    if (halt_RnnnnL !== 1'b1 || validSamp_R14H !== 4'b0000) begin
      errors++; $display("FAIL degen_idle: halt=%b valid=%b, required 1/0000", halt_RnnnnL, validSamp_R14H);
    end
    c = cycle;
    drive_box(0, 0, 0, 0);
    checks++;
    if (validSamp_R14H !== 4'b0001 || cycle != c + 1) begin
      errors++; $display("FAIL degen_next: valid=%b after %0d edges, required 0001 after 1", validSamp_R14H, cycle - c);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    set_msaa(0);
    clear_queues();
    drive_box(0, 0, 7168, 2048);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (validSamp_R14H !== 4'b0000 || halt_RnnnnL !== 1'b1) begin
      errors++; $display("FAIL midreset_ctrl: valid=%b halt=%b, required 0000/1", validSamp_R14H, halt_RnnnnL);
    end
    checks++;
    if (sample_R14S !== '0 || tri_R14S !== '0 || color_R14U !== '0) begin
      errors++; $display("FAIL midreset_data: sample=%h, required 0", sample_R14S);
    end
    rst = 1'b1;
    @(negedge clk);
    clear_queues();
    model_box(1024, 1024, 2048, 1024);
    drive_box(1024, 1024, 2048, 1024);
    checks++;
    if (sample_R14S[0][0] !== 24'd1024 || sample_R14S[1][0] !== 24'd1024) begin
      errors++; $display("FAIL midreset_restart: got x=%0d y=%0d, required 1024/1024", sample_R14S[0][0], sample_R14S[1][0]);
    end
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midreset_count: got %0d groups, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_group%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_snap();
    logic [3:0][SIGFIG-1:0] ex;
    logic [SIGFIG-1:0]      ey;
`ifdef SAMPLE_ITER_SNAP_EN
    ex = {24'd1024, 24'd768, 24'd512, 24'd256};
    ey = 24'd512;
`else
    ex = {24'd1068, 24'd812, 24'd556, 24'd300};
    ey = 24'd700;
`endif
    set_msaa(2);
    clear_queues();
    drive_box(300, 700, 1023, 700);
    checks++;
    if (sample_R14S[0] !== ex) begin errors++; $display("FAIL snap_x: got %h, required %h", sample_R14S[0], ex); end
    checks++;
    if (sample_R14S[1][0] !== ey || sample_R14S[1][3] !== ey) begin
      errors++; $display("FAIL snap_y: got %0d, required %0d", sample_R14S[1][0], ey);
    end
    checks++;
    if (validSamp_R14H !== 4'b0111) begin errors++; $display("FAIL snap_valid: got %b, required 0111", validSamp_R14H); end
    wait_idle();
  endtask

  task automatic test_random();
    int llx, lly, urx, ury;
    clear_queues();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        set_msaa(int'($urandom_range(0, 3)));
      end
      llx = int'($urandom_range(0, 8000)) - 4000;
      lly = int'($urandom_range(0, 8000)) - 4000;
      urx = llx + int'($urandom_range(0, 7 * step));
      ury = lly + int'($urandom_range(0, 5 * step));
      if ($urandom_range(0, 7) == 0) urx = llx - step;
      model_box(llx, lly, urx, ury);
      drive_box(llx, lly, urx, ury);
    end
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d groups, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_group%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst              = 1'b0;
    validTri_R13H    = 1'b0;
    tri_R13S         = '0;
    color_R13U       = '0;
    box_R13S         = '0;
    subSample_RnnnnU = 4'b1000;
    @(negedge clk);
    test_reset();
    test_msaa1();
    test_msaa4();
    test_back_to_back();
    test_degenerate();
    test_reset_mid();
    test_snap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
